// File: rtl/accumulator_stage_if.sv
// ============================================================================
// accumulator_stage_if : partial-sum input stream and result output stream
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface accumulator_stage_if #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/accumulator_stage.sv
// ============================================================================
// accumulator_stage : sums COUNT signed partial sums, scales, saturates
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module accumulator_stage #(
  parameter int IN_WIDTH  = 17,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 0,
  parameter int COUNT     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  output logic               busy,
  accumulator_stage_if.slave bus
);

  localparam int                   CNT_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(COUNT - 1);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  if (COUNT < 1) begin : g_bad_count
    $error("accumulator_stage: COUNT must be at least 1");
  end

  if (ACC_WIDTH < IN_WIDTH + $clog2(COUNT)) begin : g_bad_acc_width
    $error("accumulator_stage: ACC_WIDTH too small for IN_WIDTH and COUNT");
  end

  logic [0:0]                  state;
  logic [0:0]                  state_next;
  logic [CNT_WIDTH-1:0]        cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic signed [OUT_WIDTH-1:0] sat_data;
  logic                        sat_flag;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        out_sat_q;
  logic                        in_beat;
  logic                        last_beat;
  logic                        out_fire;

  assign in_beat   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign last_beat = (cnt == LAST_CNT);

  // cnt is 0 in HOLD, so a beat overlapping the output handshake restarts the sum
  assign acc_base = (cnt == '0) ? '0 : acc;
  assign in_ext   = ACC_WIDTH'($signed(bus.in_data));
  assign sum      = acc_base + in_ext;
  assign scaled   = sum >>> OUT_SCALE;

  if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
    localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
      sat_data = scaled[OUT_WIDTH-1:0];
      sat_flag = 1'b0;
      if (scaled > MAX_VAL) begin
        sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        sat_flag = 1'b1;
      end else if (scaled < MIN_VAL) begin
        sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        sat_flag = 1'b1;
      end
    end
  end else begin : g_no_sat
    assign sat_data = OUT_WIDTH'(scaled);
    assign sat_flag = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_ACC;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_beat && last_beat) begin
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_fire) begin
            state_next = (in_beat && last_beat) ? ST_HOLD : ST_ACC;
          end
        end
        default: state_next = ST_ACC;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = (state == ST_HOLD);
    bus.in_ready  = !rst && !clear && ((state == ST_ACC) || bus.out_ready);
    busy          = (cnt != '0) || (state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      out_sat_q <= 1'b0;
    end else if (in_beat) begin
      acc <= sum;
      cnt <= last_beat ? '0 : cnt + 1'b1;
      if (last_beat) begin
        out_data_q <= sat_data;
        out_sat_q  <= sat_flag;
      end
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_sat  = out_sat_q;

endmodule

`default_nettype wire
